// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_ctrl_pkg                                                             |
// | Shared definitions for the ALU issue controller: operation codes, FSM    |
// | state encoding, result record and small combinational helpers.           |
// | Ports: none (package).                                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package alu_ctrl_pkg;

  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_OR  = 4'b0001;
  localparam logic [3:0] F_ADD = 4'b0010;
  localparam logic [3:0] F_NOR = 4'b0011;
  localparam logic [3:0] F_XOR = 4'b0100;
  localparam logic [3:0] F_SUB = 4'b0110;
  localparam logic [3:0] F_MUL = 4'b1010;
  localparam logic [3:0] F_DIV = 4'b1011;
  localparam logic [3:0] F_REM = 4'b1100;

  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        zero;
    logic        ovf;
    logic        err;
  } res_t;

  // Build a result record; the zero flag always follows the final data.
  function automatic res_t mk_res(input logic [31:0] d, input logic ovf, input logic err);
    res_t r;
    r.data = d;
    r.zero = (d == 32'd0);
    r.ovf  = ovf;
    r.err  = err;
    return r;
  endfunction

  function automatic logic is_single(input logic [3:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) ||
           (f == F_OR)  || (f == F_NOR) || (f == F_XOR);
  endfunction

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  // Single-cycle operations; only called for codes where is_single() holds.
  function automatic res_t alu_single(input logic [3:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    logic        ov;
    r  = 32'd0;
    ov = 1'b0;
    case (f)
      F_ADD: begin
        r  = a + b;
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      F_SUB: begin
        r  = a - b;
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      F_AND:   r = a & b;
      F_OR:    r = a | b;
      F_NOR:   r = ~(a | b);
      F_XOR:   r = a ^ b;
      default: r = 32'd0;
    endcase
    return mk_res(r, ov, 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_divider                                                              |
// | Restoring unsigned 32-bit divider, one quotient bit per cycle.           |
// | Ports: clk_i, reset_i (sync, active high), start_i (load a_i/b_i),       |
// |        busy_o (iterating), done_o (one-cycle pulse, quo_o/rem_o valid),  |
// |        quo_o, rem_o.                                                     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module seq_divider
  import alu_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  localparam int CW = $clog2(DIV_ITERS + 1);

  logic [31:0]   quo_q;
  logic [31:0]   rem_q;
  logic [31:0]   div_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;

  // Partial remainder shifted left with the next dividend bit, and the trial
  // subtraction; a set borrow bit means the divisor does not fit.
  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_shift = {rem_q, quo_q[31]};
  assign w_diff  = w_shift - {1'b0, div_q};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i && !busy_q) begin
        quo_q  <= a_i;
        rem_q  <= '0;
        div_q  <= b_i;
        cnt_q  <= CW'(DIV_ITERS);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (w_diff[32]) begin
          rem_q <= w_shift[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end else begin
          rem_q <= w_diff[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_op_sequencer                                                         |
// | Multi-cycle issue controller for the shared 32-bit integer ALU.          |
// | Logic/add/sub finish in one cycle, multiply after MUL_LAT cycles, divide |
// | through the iterative seq_divider. Result and flags are registered and  |
// | held until consumed.                                                     |
// | Ports: clk_i, reset_i (sync, active high);                               |
// |        request  : req_valid_i, req_ready_o, req_funct_i, req_a_i, req_b_i|
// |        response : res_valid_o, res_ready_i, res_data_o, res_zero_o,      |
// |                   res_ovf_o, res_err_o                                   |
// | Option: define ALU_REM_EN to enable code 1100 (unsigned remainder).      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        req_funct_i,
  input  logic [DATA_W-1:0] req_a_i,
  input  logic [DATA_W-1:0] req_b_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_zero_o,
  output logic              res_ovf_o,
  output logic              res_err_o
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [3:0]      funct_q, funct_d;
  res_t            res_q, res_d;

  logic        w_accept;
  logic        w_is_div;
  logic        w_div_start;
  logic        w_div_busy;
  logic        w_div_done;
  logic [31:0] w_div_quo;
  logic [31:0] w_div_rem;
  logic [31:0] w_div_res;

  assign req_ready_o = (state_q == IDLE) && !reset_i;
  assign w_accept    = req_valid_i && req_ready_o;

`ifdef ALU_REM_EN
  assign w_is_div  = (req_funct_i == F_DIV) || (req_funct_i == F_REM);
  assign w_div_res = (funct_q == F_REM) ? w_div_rem : w_div_quo;
`else
  logic w_unused_rem;
  assign w_is_div     = (req_funct_i == F_DIV);
  assign w_div_res    = w_div_quo;
  assign w_unused_rem = ^{w_div_rem, funct_q, w_div_busy};
`endif

  seq_divider u_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (w_div_start),
    .a_i     (req_a_i),
    .b_i     (req_b_i),
    .busy_o  (w_div_busy),
    .done_o  (w_div_done),
    .quo_o   (w_div_quo),
    .rem_o   (w_div_rem)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    funct_d     = funct_q;
    res_d       = res_q;
    w_div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          a_d     = req_a_i[15:0];
          b_d     = req_b_i[15:0];
          funct_d = req_funct_i;
          if (is_single(req_funct_i)) begin
            res_d   = alu_single(req_funct_i, req_a_i, req_b_i);
            state_d = DONE;
          end else if (req_funct_i == F_MUL) begin
            if (MUL_LAT <= 1) begin
              res_d   = mk_res(mul16(req_a_i[15:0], req_b_i[15:0]), 1'b0, 1'b0);
              state_d = DONE;
            end else begin
              cnt_d   = CNT_W'(MUL_LAT - 1);
              state_d = MUL;
            end
          end else if (w_is_div) begin
            if (req_b_i == '0) begin
              // Divide by zero bypasses the divider entirely.
              res_d   = mk_res((req_funct_i == F_DIV) ? 32'hFFFF_FFFF : req_a_i,
                               1'b0, 1'b1);
              state_d = DONE;
            end else begin
              w_div_start = 1'b1;
              state_d     = DIV;
            end
          end else begin
            res_d   = mk_res(32'd0, 1'b0, 1'b1);
            state_d = DONE;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Result is captured on the final count so it is valid on DONE entry.
        if (cnt_q <= CNT_W'(1)) begin
          res_d   = mk_res(mul16(a_q, b_q), 1'b0, 1'b0);
          state_d = DONE;
        end
      end
      DIV: begin
        if (w_div_done) begin
          res_d   = mk_res(w_div_res, 1'b0, 1'b0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      funct_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      funct_q <= funct_d;
      res_q   <= res_d;
    end
  end

  assign res_valid_o = (state_q == DONE);
  assign res_data_o  = res_q.data;
  assign res_zero_o  = res_q.zero;
  assign res_ovf_o   = res_q.ovf;
  assign res_err_o   = res_q.err;

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle issue controller for the shared 32-bit integer ALU. It accepts one operation at a time over a valid/ready request channel and completes logic, add and sub in one cycle. Multiply runs through a fixed-latency countdown; divide runs through an iterative divider. The registered result, with zero, overflow and error flags, is returned over a valid/ready response channel. It sits between the decode/execute stage and the ALU datapath, and stalls the issuer while a long operation is in flight.

## Interface
- MUL_LAT, 2: cycles from multiply acceptance to result valid (≥1).
- DATA_W, 32: operand/result width. Only 32 is supported.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_funct  in  4  FunctC operation code
- req_a  in  32  operand A
- req_b  in  32  operand B
- res_valid  out  1  result available
- res_ready  in  1  consumer takes the result
- res_data  out  32  result
- res_zero  out  1  res_data == 0
- res_ovf  out  1  signed overflow (add/sub only)
- res_err  out  1  illegal code or divide by zero

## Operation
- Handshake: a request is accepted on a cycle with req_valid && req_ready. A response is consumed on a cycle with res_valid && res_ready.
- req_ready = 1 only in state IDLE and only while reset is low. It is combinational from state.
- FSM states:
  - IDLE: on accept, latch operands and funct, then branch:
    - single-cycle code → DONE
    - 1010 → MUL
    - 1011 (and 1100 when enabled) → DIV
    - illegal code → DONE with err
  - MUL: count MUL_LAT-1 down to 0, then → DONE.
  - DIV: start seq_divider and wait for div_done, then → DONE.
  - DONE: res_valid = 1. Outputs are held stable until res_ready. On consume → IDLE. There is no accept in the same cycle.
- Codes and results:
  - 0010 add: A+B
  - 0110 sub: A−B
  - 0000 and
  - 0001 or
  - 0011 nor
  - 0100 xor
  - 1010: A[15:0]×B[15:0] unsigned, giving a 32-bit product
  - 1011: unsigned quotient
  - 1100: unsigned remainder (macro-gated)
- res_ovf: add sets it when sign(A)==sign(B) && sign(sum)!=sign(A). Sub sets it when sign(A)!=sign(B) && sign(diff)!=sign(A). All other ops clear it.
- Divide by zero:
  - Skips the divider and goes IDLE→DONE directly.
  - Quotient = 32'hFFFF_FFFF, remainder = A, res_err = 1.
- Illegal code: res_data = 0, res_zero = 1, res_err = 1.
- res_zero is computed from the final res_data in every case.
- Reset:
  - All outputs are 0 during reset and on the cycle after it: res_valid = 0, res_data = 0, res_zero = 0, res_ovf = 0, res_err = 0, and req_ready = 0 while reset is high.
  - State → IDLE.
  - Reset in any state aborts the operation. The divider is cleared and no result is delivered.

## Timing
- Single-cycle op: accept at cycle T, res_valid at T+1.
- Multiply: res_valid at T+MUL_LAT.
- Divide: res_valid at T+34. This is 1 cycle load, 32 iterations and 1 cycle finish.
- Divide by zero: res_valid at T+1.
- With res_ready held high, back-to-back throughput for single-cycle ops is one op per 2 cycles (DONE→IDLE→DONE).
- res_valid stays high with res_data stable for any number of res_ready-low cycles.

## Configuration
- ALU_REM_EN defined: code 1100 returns the remainder from the divider, with the same latency as 1011.
- ALU_REM_EN undefined: 1100 is illegal (res_data = 0, res_err = 1, 1-cycle latency), and the divider's remainder port is left unused.

## Structure
- Package alu_ctrl_pkg holds:
  - FunctC localparams: F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_XOR, F_MUL, F_DIV, F_REM
  - FSM state encoding: IDLE, MUL, DIV, DONE
  - DIV_ITERS = 32
- Sub-module seq_divider: restoring unsigned divider, one bit per cycle.
  - Interface: start, a, b, busy, done, quo, rem.
  - Synchronous reset on the same reset.

## Test plan
- Reset for 3 cycles with req_valid=1 → req_ready=0 and all res_* 0; first accept on the cycle after reset drops.
- add A=32'h7FFF_FFFF, B=1 → at T+1: res_data=32'h8000_0000, res_ovf=1, res_zero=0. Then sub A=5, B=5 → res_data=0, res_zero=1, res_ovf=0.
- mul A=32'hABCD_0003, B=32'h1234_0004, MUL_LAT=2 → res_valid at T+2, res_data=12. Hold res_ready=0 for 5 cycles → data stable and req_ready=0.
- div A=100, B=7 → res_valid at T+34, res_data=14. With ALU_REM_EN, code 1100 on the same operands → res_data=2.
- div A=9, B=0 → T+1: res_data=32'hFFFF_FFFF, res_err=1. Code 4'b1111 → res_data=0, res_zero=1, res_err=1.
- Assert reset at cycle 10 of a divide → no res_valid. After release, the next add 2+3 returns 5 at T+1.
